// File: rtl/vedic_pkg.sv
// vedic_pkg: shared widths, FSM state and tag types for the vedic multiplier arbiter.
package vedic_pkg;
    localparam int OPW   = 8;
    localparam int PRODW = 16;
    localparam int IDW   = 3;

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, HALT} state_t;

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } tag_t;
endpackage

// File: rtl/vedic_rr_arbiter.sv
// vedic_rr_arbiter: one-hot round-robin grant over valid requesters, pointer advances past each accept.
import vedic_pkg::*;

module vedic_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               hold,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_id,
    output logic               grant_any
);
    logic [IDW-1:0] ptr;
    int k;

    // Scan offsets from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        k         = 0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            k = int'(ptr) + j;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (valid[k] && !hold && rst_n) begin
                grant     = '0;
                grant[k]  = 1'b1;
                grant_id  = k[IDW-1:0];
                grant_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else if (grant_any) ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
endmodule

// File: rtl/vedic_mul_arbiter.sv
// vedic_mul_arbiter: shares one pipelined vedic8x8 multiplier among NUM_REQ requesters and routes results back.
// Optional VEDIC_ARB_ISSUE_CNT_EN adds a saturating 16-bit accept counter output issue_cnt.
import vedic_pkg::*;

module vedic_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [OPW*NUM_REQ-1:0] req_a,
    input  logic [OPW*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   hold,
    output logic [OPW-1:0]         mul_a,
    output logic [OPW-1:0]         mul_b,
    input  logic [PRODW-1:0]       mul_prod,
    input  logic                   mul_overflow,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [PRODW-1:0]       rsp_prod,
    output logic                   rsp_overflow,
    output logic                   idle
`ifdef VEDIC_ARB_ISSUE_CNT_EN
    ,output logic [15:0]           issue_cnt
`endif
);
    logic [IDW-1:0] gid;
    logic           acc;
    logic           inflight;
    tag_t           tags [MUL_LAT];
    state_t         state;

    vedic_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (req_valid),
        .hold      (hold),
        .grant     (req_ready),
        .grant_id  (gid),
        .grant_any (acc)
    );

    // Work still outstanding after this edge: a new accept or any tag not yet at the last stage.
    always_comb begin
        inflight = acc;
        for (int i = 0; i < MUL_LAT - 1; i++) inflight = inflight | tags[i].valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a     <= '0;
            mul_b     <= '0;
            rsp_valid <= '0;
            for (int i = 0; i < MUL_LAT; i++) tags[i] <= '0;
        end else begin
            if (acc) begin
                mul_a <= req_a[int'(gid)*OPW +: OPW];
                mul_b <= req_b[int'(gid)*OPW +: OPW];
            end
            tags[0] <= '{valid: acc, id: gid};
            for (int i = 1; i < MUL_LAT; i++) tags[i] <= tags[i-1];
            rsp_valid <= tags[MUL_LAT-1].valid ? NUM_REQ'(1) << tags[MUL_LAT-1].id : '0;
        end
    end

    assign rsp_prod     = |rsp_valid ? mul_prod : '0;
    assign rsp_overflow = |rsp_valid & mul_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idle  <= 1'b1;
        end else begin
            state <= hold ? (inflight ? DRAIN : HALT) : (inflight ? BUSY : IDLE);
            idle  <= !hold && !inflight;
        end
    end

`ifdef VEDIC_ARB_ISSUE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) issue_cnt <= '0;
        else if (acc && issue_cnt != 16'hFFFF) issue_cnt <= issue_cnt + 1'b1;
    end
`endif
endmodule
